// File: rtl/cyborg65r2_freq_decim_if.sv
// Output-side valid/ready stream of the frequency decimator.
// The master drives window sums; the slave consumes them.
interface cyborg65r2_freq_decim_if;
  logic        out_valid;
  logic        out_ready;
  logic [18:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/cyborg65r2_freq_decim.sv
// Frequency decimator: sums per-sample encoder count differences over 2^dec_sel samples
// and queues each window sum in a small FIFO. All flops update on the falling CCO edge.
module cyborg65r2_freq_decim #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [11:0]            count_enc,
  input  logic                   enable,
  input  logic [2:0]             dec_sel,
  input  logic                   clear_ovf,
  cyborg65r2_freq_decim_if.master out_if,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, ACCUM} state_t;

  state_t          state;
  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [2:0]      n_sel;
  logic [6:0]      smp_cnt;
  logic [6:0]      n_last;
  logic [11:0]     prev;
  logic [11:0]     diff;
  logic [18:0]     acc;
  logic [18:0]     win_sum;
  logic            push;

  logic [18:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     level_next;
  logic            full;
  logic            pop;
  logic            do_push;
  logic            drop;
  logic            valid_q;

  // Reset asserts immediately but releases only after two falling edges.
  always_ff @(negedge clk or negedge resetb) begin
    if (!resetb) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Last sample index of a window is 2^n_sel - 1, formed without an 8-bit intermediate.
  always_comb begin
    n_last  = ~(7'h7f << n_sel);
    diff    = count_enc - prev;
    win_sum = acc + {7'd0, diff};
    push    = (state == ACCUM) && enable && (smp_cnt == n_last);
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      n_sel   <= 3'd0;
      prev    <= 12'd0;
      acc     <= 19'd0;
      smp_cnt <= 7'd0;
    end else if (!enable) begin
      state   <= IDLE;
      prev    <= 12'd0;
      acc     <= 19'd0;
      smp_cnt <= 7'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= PRIME;
          n_sel <= dec_sel;
        end
        PRIME: begin
          prev  <= count_enc;
          state <= ACCUM;
        end
        ACCUM: begin
          prev <= count_enc;
          if (push) begin
            acc     <= 19'd0;
            smp_cnt <= 7'd0;
          end else begin
            acc     <= win_sum;
            smp_cnt <= smp_cnt + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A full FIFO still accepts a word if the head leaves on the same edge.
  always_comb begin
    full       = (fifo_level == FULL_LVL);
    pop        = valid_q && out_if.out_ready;
    do_push    = push && (!full || pop);
    drop       = push && full && !pop;
    level_next = fifo_level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 19'd0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      valid_q    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= win_sum;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      valid_q    <= (level_next != '0);
      if (drop)           ovf <= 1'b1;
      else if (clear_ovf) ovf <= 1'b0;
    end
  end

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = mem[rd_ptr];

endmodule

// File: doc/cyborg65r2_freq_decim.md
CYBORG65R2_FREQ_DECIM -- requirements
Module: cyborg65r2_freq_decim

Interface
REQ-001 Parameter DEPTH, default 4: output FIFO depth in words, power of two.
REQ-002 clk  input  1  CCO clock; all flops SHALL update on the falling edge.
REQ-003 resetb  input  1  reset, asynchronous, active-low.
REQ-004 count_enc  input  12  unwrapped encoded time count from the encoder; wraps modulo 4096.
REQ-005 enable  input  1  level; high = measure, low = idle.
REQ-006 dec_sel  input  3  decimation window length N = 2^dec_sel samples (1..128).
REQ-007 clear_ovf  input  1  synchronous clear of the sticky overflow flag.
REQ-008 out_ready  input  1  consumer ready.
REQ-009 out_valid  output  1  FIFO head word valid.
REQ-010 out_data  output  19  window sum of per-sample count differences.
REQ-011 fifo_level  output  3  number of words held, 0..DEPTH.
REQ-012 ovf  output  1  sticky flag: a window result was dropped.

Function
REQ-013 resetb SHALL pass through a two-flop synchroniser: assertion asynchronous, deassertion on the second falling clk edge; all other flops SHALL reset from the synchronised reset.
REQ-014 The FSM SHALL have three states: IDLE, PRIME and ACCUM.
REQ-015 IDLE -> PRIME when enable=1; the entry edge SHALL also latch dec_sel into an internal N register.
REQ-016 PRIME: the edge SHALL store count_enc into prev and go to ACCUM; no difference is formed.
REQ-017 ACCUM, each edge: diff = (count_enc - prev) mod 4096, 12-bit unsigned; prev <= count_enc; acc <= acc + diff; sample counter +1.
REQ-018 Window close: on the ACCUM edge where the counter equals N-1, acc+diff SHALL be written to the FIFO, and acc and the counter SHALL clear on that same edge.
REQ-019 Windows SHALL be back-to-back with no dropped samples; the next window's first diff is taken on the following edge.
REQ-020 acc SHALL be 19 bits; 128 x 4095 fits, so no saturation logic exists.
REQ-021 From any state, enable=0 SHALL return the FSM to IDLE on the next edge; acc, the counter and prev SHALL clear and the partial window is discarded.
REQ-022 FIFO contents SHALL be retained when enable goes low.
REQ-023 dec_sel changes outside IDLE->PRIME entry SHALL be ignored.
REQ-024 Handshake: a word transfers on an edge where out_valid=1 and out_ready=1.
REQ-025 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-026 out_valid SHALL equal (fifo_level != 0), registered; the first word appears one edge after its window-close edge.
REQ-027 Write when full with no pop on the same edge: the new word SHALL be dropped, FIFO contents unchanged, ovf <= 1.
REQ-028 Write and pop on the same edge while full: both SHALL occur, fifo_level stays DEPTH, ovf unchanged.
REQ-029 Write and pop on the same edge while not full: fifo_level unchanged.
REQ-030 clear_ovf=1 SHALL clear ovf; if a drop occurs on the same edge, set wins.
REQ-031 The FIFO read/write pointers SHALL wrap modulo DEPTH.

Reset
REQ-032 While the synchronised reset is low: FSM in IDLE; acc, counter, prev and N = 0; FIFO empty.
REQ-033 Output reset values: out_valid=0, out_data=0, fifo_level=0, ovf=0.
REQ-034 Reset asserted mid-window or with a non-empty FIFO SHALL discard all data.
REQ-035 After reset release, operation SHALL resume only through IDLE -> PRIME.

Verification
REQ-036 dec_sel=2, enable=1, count_enc = 100, 166, 232, 298, 364 on consecutive edges, out_ready=1 -> out_data=264, one word, out_valid high for one cycle.
REQ-037 Wrap: dec_sel=0, count_enc 4050 then 20 -> out_data=66; count_enc 4095 then 4095 -> out_data=0.
REQ-038 Overflow: dec_sel=0, out_ready=0, constant step 10 for 7 edges -> fifo_level=4, ovf=1, head out_data=10 held stable. Then out_ready=1 with step 10 continuing -> fifo_level stays 4, no further drop. Then clear_ovf=1 -> ovf=0.
REQ-039 enable dropped after 3 of 8 samples (dec_sel=3), re-raised -> no word from the partial window; the next full window equals the sum of its 8 diffs.
REQ-040 resetb pulsed low with 2 words queued and ACCUM mid-window -> immediately out_valid=0, fifo_level=0, ovf=0; normal results return after release, PRIME and N samples.
